// File: rtl/serial_pkg.sv
// Shared definitions for the single-wire serial link (transmitter and receiver).
package serial_pkg;

  // Frame FSM states; the receiver decodes the same encoding.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  // Line levels used for framing.
  localparam logic START_BIT  = 1'b0;
  localparam logic STOP_BIT   = 1'b1;
  localparam logic IDLE_LEVEL = 1'b1;

endpackage

// File: rtl/serial_tx_bit_timer.sv
// Bit-period timer: counts 0..CLKS_PER_BIT-1 and flags the last cycle of each bit.
module bit_timer #(
  parameter int CLKS_PER_BIT = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic tick
);

  // At least one bit wide so CLKS_PER_BIT=1 still has a legal counter.
  localparam int TW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [TW-1:0] LAST = TW'(CLKS_PER_BIT - 1);

  logic [TW-1:0] count_reg;

  // Free-running period counter, held at zero while clr is asserted.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      count_reg <= '0;
    end else if (tick) begin
      count_reg <= '0;
    end else begin
      count_reg <= count_reg + TW'(1);
    end
  end

  // With CLKS_PER_BIT=1 the counter sits at zero and every cycle is a boundary.
  assign tick = (count_reg == LAST);

endmodule

// File: rtl/serial_tx.sv
// Parallel-in, serial-out transmitter: start bit, WIDTH data bits LSB-first, stop bit.
module serial_tx
  import serial_pkg::*;
#(
  parameter int WIDTH        = 8,
  parameter int CLKS_PER_BIT = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  input  logic             load,
  output logic             ready,
  output logic             tx,
  output logic             busy,
  output logic             done
);

  localparam int IW = $clog2(WIDTH);
  localparam logic [IW-1:0] LAST_IDX = IW'(WIDTH - 1);

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] shift_reg, shift_next;
  logic [IW-1:0]    bit_idx_reg, bit_idx_next;
  logic             tx_reg, tx_next;
  logic             done_reg, done_next;
  logic             tick;

  // The timer is parked at zero in IDLE so the start bit always gets a full period.
  bit_timer #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_bit_timer (
    .clk  (clk),
    .rst  (rst),
    .clr  (state_reg == IDLE),
    .tick (tick)
  );

  // State, shift register, bit index and the registered line output.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= IDLE;
      shift_reg   <= '0;
      bit_idx_reg <= '0;
      tx_reg      <= IDLE_LEVEL;
      done_reg    <= 1'b0;
    end else begin
      state_reg   <= state_next;
      shift_reg   <= shift_next;
      bit_idx_reg <= bit_idx_next;
      tx_reg      <= tx_next;
      done_reg    <= done_next;
    end
  end

  // Next-state logic; tx_next is the level for the upcoming state, so tx stays registered.
  always_comb begin
    state_next   = state_reg;
    shift_next   = shift_reg;
    bit_idx_next = bit_idx_reg;
    tx_next      = tx_reg;
    done_next    = 1'b0;
    unique case (state_reg)
      IDLE: begin
        tx_next = IDLE_LEVEL;
        if (load) begin
          state_next   = START;
          shift_next   = din;
          bit_idx_next = '0;
          tx_next      = START_BIT;
        end
      end
      START: begin
        if (tick) begin
          state_next = DATA;
          tx_next    = shift_reg[0];
        end
      end
      DATA: begin
        if (tick) begin
          // Last bit is found by compare, so a power-of-two WIDTH never wraps the index.
          if (bit_idx_reg == LAST_IDX) begin
            state_next = STOP;
            tx_next    = STOP_BIT;
          end else begin
            shift_next   = shift_reg >> 1;
            bit_idx_next = bit_idx_reg + IW'(1);
            tx_next      = shift_reg[1];
          end
        end
      end
      STOP: begin
        if (tick) begin
          state_next = IDLE;
          tx_next    = IDLE_LEVEL;
          done_next  = 1'b1;
        end
      end
      default: begin
        state_next = IDLE;
        tx_next    = IDLE_LEVEL;
      end
    endcase
  end

  assign ready = (state_reg == IDLE);
  assign busy  = (state_reg != IDLE);
  assign tx    = tx_reg;
  assign done  = done_reg;

endmodule
